// File: rtl/torpedo_hit_detector.sv
// +----------------------------------------------------------------------------+
// | torpedo_hit_detector: per-frame torpedo/asteroid/ship collision resolver   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module torpedo_hit_detector #(
  parameter int N_TORP  = 4,
  parameter int N_AST   = 8,
  parameter int SCORE_W = 16,
  parameter int POINTS  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               pix_valid,
  input  logic [N_TORP-1:0]  torp_pix,
  input  logic [N_TORP-1:0]  torp_alive,
  input  logic [N_AST-1:0]   ast_pix,
  input  logic               ship_pix,
  input  logic               ship_enable,
  input  logic               score_clear,
  output logic [N_TORP-1:0]  torp_hit,
  output logic [N_AST-1:0]   ast_hit,
  output logic               ship_hit,
  output logic [SCORE_W-1:0] score,
  output logic               overrun,
  output logic               busy
);

  localparam int IW = (N_TORP > 1) ? $clog2(N_TORP) : 1;
  localparam int CW = $clog2(N_AST + 1);
  localparam int AW = SCORE_W + CW + 7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [N_TORP-1:0][N_AST-1:0]   coll_q, coll_d;
  logic [N_TORP-1:0][N_AST-1:0]   snap_q, snap_d;
  logic                           ship_coll_q, ship_coll_d;
  logic                           ship_snap_q, ship_snap_d;
  logic [N_AST-1:0]               taken_q, taken_d;
  logic [N_TORP-1:0]              torp_pend_q, torp_pend_d;
  logic [N_AST-1:0]               ast_pend_q, ast_pend_d;
  logic [N_TORP-1:0]              torp_hit_q, torp_hit_d;
  logic [N_AST-1:0]               ast_hit_q, ast_hit_d;
  logic                           ship_hit_q, ship_hit_d;
  logic [SCORE_W-1:0]             score_q, score_d;
  logic                           overrun_q, overrun_d;

  logic [N_TORP-1:0][N_AST-1:0]   contrib;
  logic                           ship_contrib;
  logic [N_AST-1:0]               avail;
  logic [N_AST-1:0]               pick;
  logic [CW-1:0]                  kills;
  logic [AW-1:0]                  score_base;
  logic [AW-1:0]                  score_sum;
  logic [SCORE_W-1:0]             score_sat;

  // This cycle's collision contribution, used both for accumulation and for
  // the vsync snapshot so a pixel coincident with vsync is not lost.
  always_comb begin
    for (int i = 0; i < N_TORP; i++) begin
      contrib[i] = (pix_valid && torp_pix[i] && torp_alive[i]) ? ast_pix : '0;
    end
    ship_contrib = pix_valid & ship_pix & ship_enable & (|ast_pix);
  end

  // Lowest free asteroid hit by the torpedo under resolution (two's-complement isolate).
  always_comb begin
    avail = snap_q[idx_q] & ~taken_q;
    pick  = avail & (~avail + N_AST'(1));
  end

  always_comb begin
    kills = '0;
    for (int j = 0; j < N_AST; j++) begin
      kills = kills + CW'(ast_pend_q[j]);
    end
    score_base = score_clear ? '0 : AW'(score_q);
    score_sum  = score_base + (AW'(kills) * AW'(POINTS));
    score_sat  = (score_sum > AW'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                    : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    coll_d      = coll_q | contrib;
    ship_coll_d = ship_coll_q | ship_contrib;
    snap_d      = snap_q;
    ship_snap_d = ship_snap_q;
    taken_d     = taken_q;
    torp_pend_d = torp_pend_q;
    ast_pend_d  = ast_pend_q;
    torp_hit_d  = '0;
    ast_hit_d   = '0;
    ship_hit_d  = 1'b0;
    score_d     = score_clear ? '0 : score_q;
    overrun_d   = overrun_q;

    if (vsync) begin
      coll_d      = '0;
      ship_coll_d = 1'b0;
      if (state_q == S_IDLE) begin
        snap_d      = coll_q | contrib;
        ship_snap_d = ship_coll_q | ship_contrib;
        taken_d     = '0;
        idx_d       = '0;
        state_d     = S_RESOLVE;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      S_RESOLVE: begin
        if (|avail) begin
          torp_pend_d[idx_q] = 1'b1;
          taken_d            = taken_q | pick;
          ast_pend_d         = ast_pend_q | pick;
        end
        if (idx_q == IW'(N_TORP - 1)) begin
          state_d = S_EMIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_EMIT: begin
        torp_hit_d  = torp_pend_q;
        ast_hit_d   = ast_pend_q;
        ship_hit_d  = ship_snap_q;
        torp_pend_d = '0;
        ast_pend_d  = '0;
        score_d     = score_sat;
        state_d     = S_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      coll_q      <= '0;
      snap_q      <= '0;
      ship_coll_q <= 1'b0;
      ship_snap_q <= 1'b0;
      taken_q     <= '0;
      torp_pend_q <= '0;
      ast_pend_q  <= '0;
      torp_hit_q  <= '0;
      ast_hit_q   <= '0;
      ship_hit_q  <= 1'b0;
      score_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      coll_q      <= coll_d;
      snap_q      <= snap_d;
      ship_coll_q <= ship_coll_d;
      ship_snap_q <= ship_snap_d;
      taken_q     <= taken_d;
      torp_pend_q <= torp_pend_d;
      ast_pend_q  <= ast_pend_d;
      torp_hit_q  <= torp_hit_d;
      ast_hit_q   <= ast_hit_d;
      ship_hit_q  <= ship_hit_d;
      score_q     <= score_d;
      overrun_q   <= overrun_d;
    end
  end

  assign torp_hit = torp_hit_q;
  assign ast_hit  = ast_hit_q;
  assign ship_hit = ship_hit_q;
  assign score    = score_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_torpedo_hit_detector.sv
// +----------------------------------------------------------------------------+
// | tb_torpedo_hit_detector: scoreboard bench for torpedo_hit_detector         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_torpedo_hit_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        pix_valid;
  logic [3:0]  torp_pix;
  logic [3:0]  torp_alive;
  logic [7:0]  ast_pix;
  logic        ship_pix;
  logic        ship_enable;
  logic        score_clear;
  logic [3:0]  torp_hit;
  logic [7:0]  ast_hit;
  logic        ship_hit;
  logic [15:0] score;
  logic        overrun;
  logic        busy;

  torpedo_hit_detector #(
    .N_TORP(4), .N_AST(8), .SCORE_W(16), .POINTS(10)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .pix_valid(pix_valid),
    .torp_pix(torp_pix), .torp_alive(torp_alive), .ast_pix(ast_pix),
    .ship_pix(ship_pix), .ship_enable(ship_enable), .score_clear(score_clear),
    .torp_hit(torp_hit), .ast_hit(ast_hit), .ship_hit(ship_hit),
    .score(score), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  t;
    logic [7:0]  a;
    logic        s;
    logic [15:0] sc;
    logic        ov;
    logic [7:0]  len;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  logic mon_en      = 1'b0;
  logic busy_prev   = 1'b0;
  int   busy_run    = 0;

  // Monitor: a frame result is presented in the cycle busy falls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_prev && !busy) begin
        if (q.size() == 0) begin
          $display("FAIL unexpected_frame: got torp_hit=%b ast_hit=%b with no expected entry", torp_hit, ast_hit);
          miscompares++;
        end else begin
          e = q.pop_front();
          vectors++;
          if (torp_hit !== e.t) begin
            $display("FAIL torp_hit: got %b expected %b", torp_hit, e.t); miscompares++;
          end
          if (ast_hit !== e.a) begin
            $display("FAIL ast_hit: got %b expected %b", ast_hit, e.a); miscompares++;
          end
          if (ship_hit !== e.s) begin
            $display("FAIL ship_hit: got %b expected %b", ship_hit, e.s); miscompares++;
          end
          if (score !== e.sc) begin
            $display("FAIL score: got %0d expected %0d", score, e.sc); miscompares++;
          end
          if (overrun !== e.ov) begin
            $display("FAIL overrun: got %b expected %b", overrun, e.ov); miscompares++;
          end
          if (e.len != 0 && busy_run != int'(e.len)) begin
            $display("FAIL busy_length: got %0d expected %0d", busy_run, e.len); miscompares++;
          end
        end
      end else if (torp_hit != 4'b0 || ast_hit != 8'b0 || ship_hit != 1'b0) begin
        $display("FAIL spurious_pulse: got torp_hit=%b ast_hit=%b ship_hit=%b expected all 0",
                 torp_hit, ast_hit, ship_hit);
        miscompares++;
      end
      if (busy) busy_run++;
      else      busy_run = 0;
      busy_prev = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pix();
    pix_valid = 1'b0; torp_pix = '0; ast_pix = '0; ship_pix = 1'b0;
  endtask

  task automatic pix(input logic [3:0] tp, input logic [7:0] ap, input logic sp);
    pix_valid = 1'b1; torp_pix = tp; ast_pix = ap; ship_pix = sp;
    tick();
    clear_pix();
  endtask

  task automatic push(input logic [3:0] et, input logic [7:0] ea, input logic es,
                      input logic [15:0] esc, input logic eov, input logic [7:0] elen);
    exp_t x;
    x.t = et; x.a = ea; x.s = es; x.sc = esc; x.ov = eov; x.len = elen;
    q.push_back(x);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) tick();
    if (busy) begin
      $display("FAIL busy_timeout: got busy=1 expected 0 within 20 cycles");
      miscompares++;
    end
    tick();
  endtask

  // vsync with an optional coincident pixel; expected frame result pushed first.
  task automatic vs(input logic [3:0] tp, input logic [7:0] ap, input logic sp,
                    input logic [3:0] et, input logic [7:0] ea, input logic es,
                    input logic [15:0] esc, input logic eov);
    push(et, ea, es, esc, eov, 8'd5);
    pix_valid = (tp != 0) || (ap != 0) || sp;
    torp_pix = tp; ast_pix = ap; ship_pix = sp;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    clear_pix();
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; vsync = 1'b0; score_clear = 1'b0;
    torp_alive = 4'hF; ship_enable = 1'b0;
    clear_pix();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    vectors++;
    if ({torp_hit, ast_hit, ship_hit, score, overrun, busy} !== '0) begin
      $display("FAIL reset_state: got th=%b ah=%b sh=%b sc=%0d ov=%b busy=%b expected all 0",
               torp_hit, ast_hit, ship_hit, score, overrun, busy);
      miscompares++;
    end
    mon_en = 1'b1;

    // single hit
    pix(4'b0001, 8'h04, 1'b0);
    vs(4'b0, 8'h0, 1'b0, 4'b0001, 8'h04, 1'b0, 16'd10, 1'b0);

    // contention: t0,t1 on a2; t1 also on a5
    pix(4'b0011, 8'h04, 1'b0);
    pix(4'b0010, 8'h20, 1'b0);
    vs(4'b0, 8'h0, 1'b0, 4'b0011, 8'h24, 1'b0, 16'd30, 1'b0);
    pix(4'b0011, 8'h04, 1'b0);
    vs(4'b0, 8'h0, 1'b0, 4'b0001, 8'h04, 1'b0, 16'd40, 1'b0);

    // dead torpedo and disarmed ship contribute nothing
    torp_alive = 4'b1110;
    pix(4'b0001, 8'h04, 1'b0);
    pix(4'b0000, 8'h10, 1'b1);
    vs(4'b0, 8'h0, 1'b0, 4'b0, 8'h0, 1'b0, 16'd40, 1'b0);
    torp_alive = 4'hF;

    ship_enable = 1'b1;
    pix(4'b0000, 8'h10, 1'b1);
    vs(4'b0, 8'h0, 1'b0, 4'b0, 8'h0, 1'b1, 16'd40, 1'b0);
    ship_enable = 1'b0;

    // empty frame still completes
    vs(4'b0, 8'h0, 1'b0, 4'b0, 8'h0, 1'b0, 16'd40, 1'b0);

    // pixel coincident with vsync belongs to the ending frame
    vs(4'b0100, 8'h80, 1'b0, 4'b0100, 8'h80, 1'b0, 16'd50, 1'b0);
    vs(4'b0, 8'h0, 1'b0, 4'b0, 8'h0, 1'b0, 16'd50, 1'b0);

    // overrun: second vsync at T+2 discards its frame
    pix(4'b0001, 8'h01, 1'b0);
    push(4'b0001, 8'h01, 1'b0, 16'd60, 1'b1, 8'd5);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    pix_valid = 1'b1; torp_pix = 4'b0010; ast_pix = 8'h02;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    clear_pix();
    wait_idle();
    vs(4'b0, 8'h0, 1'b0, 4'b0, 8'h0, 1'b0, 16'd60, 1'b1);

    // score_clear coincident with EMIT keeps only that frame's points
    pix(4'b0011, 8'h03, 1'b0);
    push(4'b0011, 8'h03, 1'b0, 16'd20, 1'b1, 8'd5);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (4) tick();
    score_clear = 1'b1;
    tick();
    score_clear = 1'b0;
    wait_idle();

    // reset during RESOLVE abandons the frame and clears the matrix
    pix(4'b0001, 8'h01, 1'b0);
    push(4'b0, 8'h0, 1'b0, 16'd0, 1'b0, 8'd0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    pix(4'b0010, 8'h02, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    vs(4'b0, 8'h0, 1'b0, 4'b0, 8'h0, 1'b0, 16'd0, 1'b0);

    // saturation: climb to 65520 in 40-point frames, then 65530, then clamp
    for (int k = 1; k <= 1638; k++) begin
      pix(4'hF, 8'h0F, 1'b0);
      vs(4'b0, 8'h0, 1'b0, 4'hF, 8'h0F, 1'b0, 16'(k * 40), 1'b0);
    end
    pix(4'b0001, 8'h01, 1'b0);
    vs(4'b0, 8'h0, 1'b0, 4'b0001, 8'h01, 1'b0, 16'd65530, 1'b0);
    pix(4'b0001, 8'h01, 1'b0);
    vs(4'b0, 8'h0, 1'b0, 4'b0001, 8'h01, 1'b0, 16'd65535, 1'b0);
    pix(4'hF, 8'h0F, 1'b0);
    vs(4'b0, 8'h0, 1'b0, 4'hF, 8'h0F, 1'b0, 16'd65535, 1'b0);

    repeat (3) tick();
    if (q.size() != 0) begin
      $display("FAIL pending_frames: got %0d unconsumed expected 0", q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/torpedo_hit_detector.md
Name: torpedo_hit_detector

Overview:
- Consumer side of the torpedo `hit` interface. It watches per-pixel draw flags from every torpedo, asteroid and the ship during the VGA scan, and accumulates a torpedo×asteroid collision matrix for each frame.
- After each vsync it resolves the matrix one-to-one and emits single-cycle `hit` pulses back to the torpedo units, destroy pulses to the asteroid units, a ship-hit pulse and a running score.
- It sits beside the VGA draw chain, at the same level as the torpedo and asteroid units.

Parameters:
- N_TORP, 4, number of torpedo units (one bit per torpedo on torpedo buses).
- N_AST, 8, number of asteroid units.
- SCORE_W, 16, score counter width.
- POINTS, 10, score added per destroyed asteroid.

Ports:
- clk  in  1  system clock (25 MHz pixel clock).
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  one-cycle frame pulse, same pulse fed to the torpedo units.
- pix_valid  in  1  current cycle is an active-video pixel.
- torp_pix  in  N_TORP  torpedo i draws an opaque pixel at the current position.
- torp_alive  in  N_TORP  torpedo i is flying (`t_fire` from each unit).
- ast_pix  in  N_AST  asteroid j draws an opaque pixel at the current position.
- ship_pix  in  1  ship draws an opaque pixel at the current position.
- ship_enable  in  1  ship collisions are armed (0 during respawn invulnerability).
- score_clear  in  1  zeroes the score.
- torp_hit  out  N_TORP  one-cycle pulse per torpedo that scored; drives each unit's `hit`.
- ast_hit  out  N_AST  one-cycle pulse per destroyed asteroid.
- ship_hit  out  1  one-cycle pulse when the ship touched any asteroid.
- score  out  SCORE_W  accumulated score, saturating.
- overrun  out  1  sticky flag: a vsync arrived while resolution was busy.
- busy  out  1  FSM is not IDLE.

Behaviour:
- **Reset.** Synchronous reset clears everything and dominates all other inputs:
  - torp_hit, ast_hit, ship_hit, score, overrun and busy all go to 0.
  - The collision matrix coll[N_TORP][N_AST], ship_coll and the snapshot registers are cleared.
  - The FSM goes to IDLE.
  - Reset mid-RESOLVE or mid-EMIT abandons the frame; no pulses are emitted.
- **Accumulation** (every cycle, all states):
  - If pix_valid, then coll[i][j] |= torp_pix[i] & torp_alive[i] & ast_pix[j].
  - If pix_valid, then ship_coll |= ship_pix & ship_enable & (|ast_pix).
  - Inputs are used unregistered; the matrix updates on the next edge.
- **Vsync in IDLE:**
  - snap <= coll merged with the current cycle's contribution, so a pixel coincident with vsync is kept.
  - ship_snap is taken the same way from ship_coll.
  - coll and ship_coll are cleared.
  - The FSM moves to RESOLVE with i=0 and taken_mask=0.
- **Vsync when not IDLE:**
  - coll and ship_coll are cleared and that frame's data is discarded.
  - overrun is set and stays set until reset.
  - The resolution in progress is unaffected.
- **FSM** (IDLE -> RESOLVE -> EMIT -> IDLE):
  - **RESOLVE**, one torpedo per cycle, for i = 0..N_TORP-1:
    - avail = snap[i] & ~taken_mask.
    - If avail != 0, pick j = the lowest set index: set torp_hit_pend[i], set taken_mask[j], set ast_hit_pend[j].
    - When i reaches N_TORP-1, go to EMIT.
    - Lower torpedo indices win. Each torpedo kills at most one asteroid and each asteroid is killed at most once.
  - **EMIT**, exactly one cycle:
    - torp_hit <= torp_hit_pend, ast_hit <= ast_hit_pend, ship_hit <= ship_snap.
    - The pending registers are cleared, then the FSM returns to IDLE.
  - **Output timing:** outputs are registered. A vsync at cycle T produces pulses high during cycle T+N_TORP+2 only; all pulse outputs are 0 in every other cycle.
  - **busy** is high from T+1 through T+N_TORP+1.
- **Score:**
  - On the EMIT edge, score <= min(score + POINTS*popcount(ast_hit_pend), 2^SCORE_W-1).
  - The product and sum are computed at SCORE_W + clog2(N_AST+1) + 7 bits before saturation.
  - score_clear sets score to 0. If score_clear and EMIT coincide, the result is the points of that EMIT alone (clear first, then add).
- **Boundary conditions:**
  - A torpedo that dies (torp_alive=0) before its pixels are drawn contributes nothing.
  - An all-zero snapshot still runs RESOLVE/EMIT and emits all-zero outputs.
  - Torpedo–torpedo and asteroid–asteroid overlaps are ignored.

Test Plan:
- **Single hit.** Reset, then torp_pix=0001 and ast_pix=00000100 with pix_valid on one pixel, then vsync at cycle T → at T+6 (N_TORP=4) torp_hit=0001 and ast_hit=00000100 for one cycle; score=10.
- **Contention.** Torpedoes 0 and 1 both overlap asteroid 2, and torpedo 1 also overlaps asteroid 5; vsync → torp_hit=0011, ast_hit=00100100, score +20. Second case: torpedo 1 overlaps only asteroid 2 → torp_hit=0001, ast_hit=00000100.
- **Masking.** Overlap with torp_alive[0]=0 → no pulses, score unchanged. ship_pix & ast_pix with ship_enable=0 → ship_hit=0. The same overlap with ship_enable=1 → ship_hit pulse at T+6.
- **Vsync coincidence and overrun.**
  - Overlapping pixel in the same cycle as vsync → hit reported for that frame, and the next frame's matrix is empty.
  - Second vsync at T+2 → overrun=1; first frame's pulses still emitted at T+6; second frame produces no pulses.
- **Saturation and clear.**
  - Preload score to 65530, then destroy 1 asteroid → 65535.
  - score_clear asserted in the EMIT cycle with 2 kills → score=20.
- **Reset mid-operation.** Assert reset at T+3 during RESOLVE → no pulses at T+6, busy=0, score=0, and the matrix is empty on the next vsync.
